// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding-request memory port feeding a
// 2-entry {pc,inst} buffer, with branch redirect that waits out an in-flight request.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid
);

   typedef enum logic {
      ST_RUN,
      ST_DRAIN
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [31:0] pc_mem_q   [2];
   logic [31:0] inst_mem_q [2];

   logic        req;
   logic        ack_ok;
   logic        head_valid;
   logic        push;
   logic        pop;
   logic        flush;
   logic        wr_idx;
   logic [31:0] target;

   always_comb begin
      state_d   = state_q;
      fpc_d     = fpc_q;
      pend_pc_d = pend_pc_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;

      head_valid = (count_q != 2'd0);
      target     = branch_target_i & 32'hFFFF_FFFC;
      wr_idx     = rd_ptr_q ^ count_q[0];
      req        = (state_q == ST_DRAIN) ? 1'b1 : (count_q != 2'd2);
      ack_ok     = req & imem_ack_i;

      unique case (state_q)
         ST_RUN: begin
            if (branch_flag_i) begin
               flush = 1'b1;
               // An unanswered request must keep its address, so park the target.
               if (req && !imem_ack_i) begin
                  pend_pc_d = target;
                  state_d   = ST_DRAIN;
               end else begin
                  fpc_d = target;
               end
            end else begin
               if (ack_ok) begin
                  push  = 1'b1;
                  fpc_d = fpc_q + 32'd4;
               end
               if (head_valid && !stall_i) begin
                  pop = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (branch_flag_i) begin
               flush     = 1'b1;
               pend_pc_d = target;
            end
            if (ack_ok) begin
               state_d = ST_RUN;
               fpc_d   = branch_flag_i ? target : pend_pc_q;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01: begin
               count_d  = count_q - 2'd1;
               rd_ptr_d = ~rd_ptr_q;
            end
            2'b11:   rd_ptr_d = ~rd_ptr_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         fpc_q     <= RESET_PC & 32'hFFFF_FFFC;
         pend_pc_q <= '0;
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         fpc_q     <= fpc_d;
         pend_pc_q <= pend_pc_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         if (push) begin
            pc_mem_q[wr_idx]   <= fpc_q;
            inst_mem_q[wr_idx] <= imem_rdata_i;
         end
      end
   end

   always_comb begin
      imem_req_o  = rst & req;
      imem_addr_o = fpc_q;
      if_valid    = rst & head_valid;
      if_pc       = if_valid ? pc_mem_q[rd_ptr_q]   : '0;
      if_inst     = if_valid ? inst_mem_q[rd_ptr_q] : '0;
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vector table plus wrap/throughput sequence.
module tb_if_fetch;

   localparam logic [31:0] K = 32'hA5A5_A5A5;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;

   int unsigned n_checks;
   int unsigned n_fail;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ack_i      (imem_ack_i),
      .imem_rdata_i    (imem_rdata_i),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .if_valid        (if_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t tv [31];

   function automatic vec_t mk(input logic r, input logic s, input logic b,
                               input logic [31:0] t, input logic a,
                               input logic [31:0] rd, input logic er,
                               input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei);
      vec_t v;
      v.rst = r;  v.stall = s;  v.br = b;  v.tgt = t;  v.ack = a;  v.rdata = rd;
      v.e_req = er;  v.e_addr = ea;  v.e_valid = ev;  v.e_pc = ep;  v.e_inst = ei;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic a, input logic [31:0] rd);
      @(negedge clk);
      rst = r;  stall_i = s;  branch_flag_i = b;  branch_target_i = t;
      imem_ack_i = a;  imem_rdata_i = rd;
      #1;
   endtask

   task automatic chk_out(input string tag, input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ep, input logic [31:0] ei);
      chk({tag, " req"}, {31'd0, imem_req_o}, {31'd0, er});
      if (er) chk({tag, " addr"}, imem_addr_o, ea);
      chk({tag, " valid"}, {31'd0, if_valid}, {31'd0, ev});
      chk({tag, " pc"}, if_pc, ep);
      chk({tag, " inst"}, if_inst, ei);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;  stall_i = 1'b0;  branch_flag_i = 1'b0;
      branch_target_i = '0;  imem_ack_i = 1'b0;  imem_rdata_i = '0;

      //           rst  stl  br   tgt           ack  rdata            req  addr          vld  pc            inst
      tv[0]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,32'h1234_5678,  1'b0,32'h0,       1'b0,32'h0,       32'h0);
      tv[1]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b0,32'h0,       1'b0,32'h0,       32'h0);
      tv[2]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h0^K,        1'b1,32'h0,       1'b0,32'h0,       32'h0);
      tv[3]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h4^K,        1'b1,32'h4,       1'b1,32'h0,       32'h0^K);
      tv[4]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h8^K,        1'b1,32'h8,       1'b1,32'h4,       32'h4^K);
      tv[5]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b1,32'hC^K,        1'b1,32'hC,       1'b1,32'h8,       32'h8^K);
      tv[6]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h0,          1'b0,32'h10,      1'b1,32'h8,       32'h8^K);
      tv[7]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h0,          1'b0,32'h10,      1'b1,32'h8,       32'h8^K);
      tv[8]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h0,          1'b0,32'h10,      1'b1,32'h8,       32'h8^K);
      tv[9]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h0,          1'b0,32'h10,      1'b1,32'h8,       32'h8^K);
      tv[10] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b0,32'h10,      1'b1,32'h8,       32'h8^K);
      tv[11] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h10^K,       1'b1,32'h10,      1'b1,32'hC,       32'hC^K);
      tv[12] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b1,32'h14,      1'b1,32'h10,      32'h10^K);
      tv[13] = mk(1'b1,1'b0,1'b1,32'h103,     1'b0,32'h0,          1'b1,32'h14,      1'b0,32'h0,       32'h0);
      tv[14] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b1,32'h14,      1'b0,32'h0,       32'h0);
      tv[15] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h14^K,       1'b1,32'h14,      1'b0,32'h0,       32'h0);
      tv[16] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h100^K,      1'b1,32'h100,     1'b0,32'h0,       32'h0);
      tv[17] = mk(1'b1,1'b0,1'b1,32'h200,     1'b1,32'h104^K,      1'b1,32'h104,     1'b1,32'h100,     32'h100^K);
      tv[18] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b1,32'h200,     1'b0,32'h0,       32'h0);
      tv[19] = mk(1'b1,1'b0,1'b1,32'h300,     1'b0,32'h0,          1'b1,32'h200,     1'b0,32'h0,       32'h0);
      tv[20] = mk(1'b1,1'b0,1'b1,32'h380,     1'b0,32'h0,          1'b1,32'h200,     1'b0,32'h0,       32'h0);
      tv[21] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h200^K,      1'b1,32'h200,     1'b0,32'h0,       32'h0);
      tv[22] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b1,32'h380,     1'b0,32'h0,       32'h0);
      tv[23] = mk(1'b1,1'b0,1'b1,32'h500,     1'b0,32'h0,          1'b1,32'h380,     1'b0,32'h0,       32'h0);
      tv[24] = mk(1'b1,1'b0,1'b1,32'h404,     1'b1,32'h380^K,      1'b1,32'h380,     1'b0,32'h0,       32'h0);
      tv[25] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h404^K,      1'b1,32'h404,     1'b0,32'h0,       32'h0);
      tv[26] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b1,32'h408,     1'b1,32'h404,     32'h404^K);
      tv[27] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,32'h408^K,      1'b0,32'h0,       1'b0,32'h0,       32'h0);
      tv[28] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b1,32'h0,       1'b0,32'h0,       32'h0);
      tv[29] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h0^K,        1'b1,32'h0,       1'b0,32'h0,       32'h0);
      tv[30] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,          1'b1,32'h4,       1'b1,32'h0,       32'h0^K);

      for (int i = 0; i < 31; i++) begin
         drive(tv[i].rst, tv[i].stall, tv[i].br, tv[i].tgt, tv[i].ack, tv[i].rdata);
         chk_out($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr,
                 tv[i].e_valid, tv[i].e_pc, tv[i].e_inst);
      end

      // Unaligned redirect next to an ack, then fetch across the 2^32 wrap.
      drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h4 ^ K);
      chk_out("wrap_br", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC ^ K);
      chk_out("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         logic [31:0] p;
         a = 32'(i) * 32'd4;
         p = a - 32'd4;
         drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a ^ K);
         chk_out($sformatf("stream%0d", i), 1'b1, a, 1'b1, p, p ^ K);
      end

      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
